// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shift stage, LSB first.
// A word accepted on the valid/ready handshake streams out one bit per clock
// starting the cycle after the accepting edge; back-to-back words are gapless.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the data bits) as the final, sout_last-marked bit of every frame.
// rst is asynchronous and active-low; all outputs except d_ready are registered.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_SHIFT  = 2'd1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_vld;
  logic             r_last;
  logic             r_busy;
`ifdef PISO_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_sout_nxt;
  logic             w_vld_nxt;
  logic             w_last_nxt;
  logic             w_busy_nxt;
  logic             w_last_bit;
  logic             w_load;

  // Identify the cycle currently presenting the final bit of a frame.
  always_comb begin
    w_last_bit = 1'b0;
`ifdef PISO_PARITY_EN
    w_last_bit = (r_state == S_PARITY);
`else
    w_last_bit = (r_state == S_SHIFT) && (r_cnt == CNT_MAX);
`endif
  end

  // Ready only depends on state and reset, so a new word can be taken on the
  // last-bit cycle and the next frame starts without an idle cycle.
  assign d_ready = rst & ((r_state == S_IDLE) | w_last_bit);
  assign w_load  = d_valid & d_ready;

  // Next-state, counter and shift-register update.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = d_in;
`ifdef PISO_PARITY_EN
          w_par_nxt   = ^d_in;
`endif
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_MAX) begin
`ifdef PISO_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          if (w_load) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
            w_shift_nxt = d_in;
          end else begin
            w_state_nxt = S_IDLE;
          end
`endif
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (w_load) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = d_in;
          w_par_nxt   = ^d_in;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state so the
  // serial outputs can be registered without adding latency.
  always_comb begin
    w_sout_nxt = 1'b0;
    w_vld_nxt  = 1'b0;
    w_last_nxt = 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_SHIFT: begin
        w_sout_nxt = w_shift_nxt[0];
        w_vld_nxt  = 1'b1;
`ifndef PISO_PARITY_EN
        w_last_nxt = (w_cnt_nxt == CNT_MAX);
`endif
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        w_sout_nxt = w_par_nxt;
        w_vld_nxt  = 1'b1;
        w_last_nxt = 1'b1;
      end
`endif
      default: begin
        w_sout_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sout  <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_sout  <= w_sout_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_vld;
  assign sout_last  = r_last;
  assign busy       = r_busy;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at WIDTH=4 (also covers PISO_PARITY_EN
// when the macro is defined for both files).
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] d_in;
  logic         d_valid;
  logic         d_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_last;
  logic         busy;

  int n_chk;
  int n_err;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic v,
                         input logic l, input logic r, input logic b);
    check({tag, ".sout"},  32'(sout),       32'(s));
    check({tag, ".valid"}, 32'(sout_valid), 32'(v));
    check({tag, ".last"},  32'(sout_last),  32'(l));
    check({tag, ".ready"}, 32'(d_ready),    32'(r));
    check({tag, ".busy"},  32'(busy),       32'(b));
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one frame of word w already in flight (called the cycle after the
  // accepting edge). On the last-bit cycle, offer nxt if has_next, else drop
  // d_valid. Returns just after the edge that ends the frame.
  task automatic send_frame(input string tag, input logic [W-1:0] w,
                            input logic [W-1:0] nxt, input bit has_next);
    logic eb;
    logic il;
    for (int i = 0; i < FL; i++) begin
      eb = (i < W) ? w[i] : ^w;
      il = (i == FL - 1);
      chk_out($sformatf("%s.b%0d", tag, i), eb, 1'b1, il, il, 1'b1);
      if (il) begin
        d_valid = has_next;
        if (has_next) d_in = nxt;
      end
      step();
    end
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b0;
    d_valid = 1'b1;
    d_in    = 4'hA;

    // Reset held with a word offered: everything quiet, not ready.
    step();
    step();
    chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_release.ready", 32'(d_ready), 32'd1);

    // Single word 4'hA.
    step();
    d_valid = 1'b0;
    d_in    = 4'h0;
    send_frame("single_A", 4'hA, 4'h0, 1'b0);
    chk_out("single_A.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back 4'h3 then 4'hC with d_valid held.
    d_valid = 1'b1;
    d_in    = 4'h3;
    step();
    send_frame("b2b_3", 4'h3, 4'hC, 1'b1);
    d_valid = 1'b0;
    send_frame("b2b_C", 4'hC, 4'h0, 1'b0);
    chk_out("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 4'h6 in flight while 4'hF is offered; 4'hF only taken on last bit.
    d_valid = 1'b1;
    d_in    = 4'h6;
    step();
    d_in = 4'hF;
    send_frame("busy_6", 4'h6, 4'hF, 1'b1);
    d_valid = 1'b0;
    send_frame("busy_F", 4'hF, 4'h0, 1'b0);
    chk_out("busy.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-frame reset during 4'h9, then a clean 4'h5.
    d_valid = 1'b1;
    d_in    = 4'h9;
    step();
    d_valid = 1'b0;
    chk_out("mid_9.b0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("mid_9.b1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    d_valid = 1'b1;
    rst     = 1'b0;
    #1;
    chk_out("mid_rst.now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("mid_rst.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst  = 1'b1;
    d_in = 4'h5;
    #1;
    check("mid_rel.ready", 32'(d_ready), 32'd1);
    step();
    d_valid = 1'b0;
    send_frame("mid_5", 4'h5, 4'h0, 1'b0);
    chk_out("mid_5.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PISO_PARITY_EN
    // Parity frames: 4'h7 -> 1,1,1,0,1 and 4'h0 -> 0,0,0,0,0.
    d_valid = 1'b1;
    d_in    = 4'h7;
    step();
    send_frame("par_7", 4'h7, 4'h0, 1'b1);
    d_valid = 1'b0;
    send_frame("par_0", 4'h0, 4'h0, 1'b0);
    chk_out("par.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift stage that sends a captured parallel word one bit per clock, LSB first, with a valid/ready load handshake on the parallel side. It is the transmit-side counterpart of the team's parallel capture register: upstream logic presents a word, and the block streams it onto a single-bit link with a valid and end-of-frame marker. Back-to-back words stream with no idle cycle between frames.

## Interface
- `WIDTH`, default 4: data word width in bits, minimum 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `d_in`  input  WIDTH  parallel word; sampled only on an accepted load.
- `d_valid`  input  1  upstream has a word on `d_in`.
- `d_ready`  output  1  block can accept a word this cycle.
- `sout`  output  1  serial data bit.
- `sout_valid`  output  1  `sout` carries a frame bit this cycle.
- `sout_last`  output  1  final bit of the current frame.
- `busy`  output  1  a frame is in progress.

## Operation
- Load is accepted at a rising `clk` edge when `d_valid && d_ready`. `d_in` is copied into an internal shift register and the bit counter is cleared.
- FSM states:
  - IDLE: `d_ready`=1, `sout_valid`=0. An accepted load moves to SHIFT.
  - SHIFT: presents bit `cnt` of the captured word on `sout`, with `cnt` running 0..WIDTH-1.
    - Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.
    - At `cnt`=WIDTH-1: go to PARITY if that state is compiled in; otherwise go to SHIFT with `cnt`=0 if a load is accepted, else go to IDLE.
  - PARITY (macro only): one cycle presenting the even-parity bit, i.e. the XOR of the data bits. Then go to SHIFT if a load is accepted, else go to IDLE.
- `d_ready` = `rst` AND (IDLE OR last-bit cycle). It is combinational from state, so back-to-back frames are gapless.
- `busy` = state is not IDLE.
- `sout_last` is high exactly on the final bit of the frame: data MSB, or the parity bit when compiled in.
- `d_valid` while `d_ready`=0 is ignored. Upstream holds `d_valid`/`d_in` until accepted.
- `d_in` changing after acceptance does not affect the frame in flight.
- Reset:
  - Asserting `rst` low at any time, including mid-frame, immediately forces IDLE, clears the counter and shift register, and drives `sout`=0, `sout_valid`=0, `sout_last`=0, `busy`=0, `d_ready`=0.
  - The partial frame is discarded, not resumed.
  - After `rst` goes high, `d_ready`=1 in the same cycle.
- Outside SHIFT/PARITY, `sout` is driven 0.

## Timing
- Latency: the first bit appears on `sout` in the cycle immediately after the accepting edge, as a registered output.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- Throughput: one word per frame length with `d_valid` held high; zero-cycle gap between frames.
- All outputs except `d_ready` are registered. `d_ready` has no combinational path from `d_valid` or `d_in`.

## Configuration
- `PISO_PARITY_EN` defined:
  - The PARITY state is present and each frame is WIDTH+1 bits.
  - The trailing bit is the even parity of the data word.
  - `sout_last` marks the parity bit.
- Not defined:
  - The PARITY state and its logic are absent and frames are WIDTH bits.
  - `sout_last` marks the data MSB.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold `rst`=0 with `d_valid`=1 → `d_ready`, `sout`, `sout_valid`, `sout_last`, `busy` all 0. Release → `d_ready`=1 immediately.
- Single word 4'hA accepted at edge N → cycles N+1..N+4 give `sout`=0,1,0,1 with `sout_valid`=1 and `sout_last` only at N+4. `d_ready`=0 at N+1..N+3 and back to 1 at N+4; `busy`=0 at N+5.
- Back-to-back: 4'h3 then 4'hC with `d_valid` held → 8 contiguous valid bits 1,1,0,0,0,0,1,1 with no gap. `sout_last` pulses on bits 4 and 8.
- Ignore while busy: load 4'h6, then drive `d_in`=4'hF with `d_valid`=1 during bits 1-3 → serial output stays 0,1,1,0. 4'hF is accepted on the last-bit cycle and streams next.
- Mid-frame reset: load 4'h9 and assert `rst`=0 after 2 bits → all outputs 0 at once. Release and load 4'h5 → clean 1,0,1,0.
- With `PISO_PARITY_EN`: 4'h7 → 1,1,1,0,1 with `sout_last` on bit 5. 4'h0 → 0,0,0,0,0.
